// File: rtl/tdc_coarse_core.sv
// Multi-channel coarse TDC: counts clk cycles from a START edge to the first rising edge
// on each STOP channel, then drains one result per channel over a valid/ready port.
module tdc_coarse_core #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             arm,
    input  logic             start_in,
    input  logic [N_CH-1:0]  stop_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_data,
    output logic [CH_W-1:0]  result_ch,
    output logic             result_timeout
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDrain} state_e;

    state_e state_q;

    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [N_CH-1:0]        stop_sync_q [SYNC_STAGES];
    logic                   start_prev_q;
    logic [N_CH-1:0]        stop_prev_q;
    logic                   start_edge;
    logic [N_CH-1:0]        stop_edge;

    logic [CNT_W-1:0]       cnt_q;
    logic [N_CH-1:0]        hit_q, hit_d;
    logic [N_CH-1:0]        to_q, to_d;
    logic [CNT_W-1:0]       cap_q [N_CH];
    logic [CNT_W-1:0]       cap_d [N_CH];
    logic [CH_W-1:0]        drain_idx_q;
    logic [CH_W-1:0]        next_idx;
    logic                   last_idx;
    logic                   all_hit;

    // Synchronise the asynchronous START/STOP inputs and keep one extra flop for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stop_sync_q[i] <= '0;
            end
        end else begin
            start_sync_q   <= {start_sync_q[SYNC_STAGES-2:0], start_in};
            start_prev_q   <= start_sync_q[SYNC_STAGES-1];
            stop_prev_q    <= stop_sync_q[SYNC_STAGES-1];
            stop_sync_q[0] <= stop_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stop_sync_q[i] <= stop_sync_q[i-1];
            end
        end
    end

    assign start_edge = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
    assign stop_edge  = stop_sync_q[SYNC_STAGES-1] & ~stop_prev_q;

    // Per-channel capture: first stop edge in RUN wins; unhit channels time out at CMAX.
    always_comb begin
        hit_d = hit_q;
        to_d  = to_q;
        for (int k = 0; k < N_CH; k++) begin
            cap_d[k] = cap_q[k];
        end
        if (state_q == StRun) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!hit_q[k]) begin
                    if (stop_edge[k]) begin
                        hit_d[k] = 1'b1;
                        cap_d[k] = cnt_q;
                        to_d[k]  = 1'b0;
                    end else if (cnt_q == CMAX) begin
                        hit_d[k] = 1'b1;
                        cap_d[k] = CMAX;
                        to_d[k]  = 1'b1;
                    end
                end
            end
        end
    end

    // Every channel resolves at the latest in the CMAX cycle, so all_hit also covers saturation.
    assign all_hit  = &hit_d;
    assign next_idx = drain_idx_q + CH_W'(1);
    assign last_idx = (drain_idx_q == CH_W'(N_CH - 1));

    // Measurement FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            hit_q          <= '0;
            to_q           <= '0;
            drain_idx_q    <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_data    <= '0;
            result_ch      <= '0;
            result_timeout <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cap_q[k] <= '0;
            end
        end else if (!ena) begin
            // Abort: drop everything, including results not yet drained.
            state_q      <= StIdle;
            cnt_q        <= '0;
            hit_q        <= '0;
            to_q         <= '0;
            drain_idx_q  <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            hit_q <= hit_d;
            to_q  <= to_d;
            cap_q <= cap_d;
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_q <= StArmed;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        hit_q   <= '0;
                        to_q    <= '0;
                    end
                end
                StArmed: begin
                    if (start_edge) begin
                        state_q <= StRun;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StRun: begin
                    if (cnt_q != CMAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (all_hit) begin
                        state_q        <= StDrain;
                        drain_idx_q    <= '0;
                        result_valid   <= 1'b1;
                        result_ch      <= '0;
                        result_data    <= cap_d[0];
                        result_timeout <= to_d[0];
                    end
                end
                StDrain: begin
                    if (result_valid && result_ready) begin
                        if (last_idx) begin
                            state_q      <= StIdle;
                            result_valid <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            drain_idx_q    <= next_idx;
                            result_ch      <= next_idx;
                            result_data    <= cap_q[next_idx];
                            result_timeout <= to_q[next_idx];
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
